alu_share_arbiter: RTL
======================

# alu_share_arbiter

Shares one combinational `Simple_ALU` between two issue lanes of the execute stage. A round-robin grant picks one request per cycle. The selected operands go to the single ALU instance, and the result, flags and tag are captured into a one-entry output register that drains to writeback under valid/ready backpressure. A mispredict flush empties the register, and a saturating counter records grant conflicts for performance analysis.

## Interface
- `TAG_W`, default 7: width of the destination physical-register tag carried with each op.
- `CNT_W`, default 16: width of the conflict counter.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid_i`  in  2  per-lane request valid.
- `req_ready_o`  out  2  per-lane accept; at most one bit set.
- `req0_opcode_i`, `req1_opcode_i`  in  `SIZE_OPCODE_I`  ALU opcode.
- `req0_data1_i`, `req0_data2_i`, `req1_data1_i`, `req1_data2_i`  in  `SIZE_DATA`  operands.
- `req0_immd_i`, `req1_immd_i`  in  `SIZE_IMMEDIATE`  immediate.
- `req0_tag_i`, `req1_tag_i`  in  `TAG_W`  destination tag.
- `flush_i`  in  1  mispredict recovery.
- `out_valid_o`  out  1  output register holds a result.
- `out_ready_i`  in  1  writeback accepts the result.
- `out_result_o`  out  `SIZE_DATA`  registered ALU result.
- `out_flags_o`  out  `EXECUTION_FLAGS`  registered ALU flags.
- `out_tag_o`  out  `TAG_W`  registered tag.
- `out_src_o`  out  1  lane that produced the result.
- `conflict_cnt_o`  out  `CNT_W`  number of cycles in which both lanes were valid and one was granted.

## Operation
- `can_accept = !flush_i && (!out_valid_o || out_ready_i)`.
- Grant rule:
  - Only one lane valid: that lane is granted when `can_accept`.
  - Both lanes valid: the lane not equal to `last_grant` is granted.
  - `req_ready_o` equals the grant vector. It is combinational from `req_valid_i`, `out_ready_i`, `flush_i` and state.
- Accept = valid && ready on a lane. On accept:
  - The mux drives that lane's opcode, operands and immediate into the ALU.
  - The result, flags, tag and lane index load into the output register.
  - `out_valid_o` is set and `last_grant` updates to the granted lane.
- When the mux is idle it selects lane 0. This choice is unobservable.
- Drain without accept: `out_valid_o && out_ready_i` clears `out_valid_o`.
- Drain with accept in the same cycle: the register reloads and `out_valid_o` stays 1. This gives full throughput of 1 op/cycle.
- Backpressure (`out_valid_o && !out_ready_i`): the register holds all fields stable and both ready bits are 0.
- Flush has priority over everything:
  - `out_valid_o` goes to 0 at the next edge.
  - No lane is granted in the flush cycle.
  - `last_grant` and `conflict_cnt_o` are unchanged.
  - Data fields may keep stale values.
- `conflict_cnt_o` increments when both lanes are valid and a grant occurs. It saturates at all-ones and never wraps.
- A NOP is accepted like any other op. It produces result 0 with flags `6'b000100`.
- State machine (output register occupancy):
  - EMPTY → FULL on accept.
  - FULL → FULL on drain+accept, or on stall.
  - FULL → EMPTY on drain without accept, or on flush.
  - EMPTY stays EMPTY on flush.

## Timing
- Latency: an op accepted at edge N appears on `out_*` immediately after edge N. Writeback may take it at edge N+1.
- Reset (asynchronous, any time, including mid-stall):
  - `out_valid_o` = 0.
  - `out_result_o` = 0, `out_flags_o` = 0, `out_tag_o` = 0, `out_src_o` = 0.
  - `conflict_cnt_o` = 0.
  - `last_grant` = 1, so lane 0 wins the first conflict.
  - `req_ready_o` = 0 while reset is asserted.
- Fairness: a lane held valid is granted within 2 accepts.
- The critical path is ALU mux plus ALU combinational logic into the output register. There are no added pipeline stages.

## Structure
- The opcode, `SIZE_*` and `EXECUTION_FLAGS` macros come from the existing shared parameter include. This block adds no new shared constants; `TAG_W` and `CNT_W` are local parameters.
- Natural sub-module: `rr_arb2`, a two-way round-robin arbiter. It holds the `last_grant` flop and has `valid[1:0]`, `en` and `grant[1:0]` ports. The block also instantiates one `Simple_ALU`.

## Test plan
- Reset: lane 0 `ADD` with 5 and 7, tag 3, `out_ready_i`=1 → next cycle `out_result_o`=12, flags `6'b010100`, tag 3, `out_src_o`=0.
- Both lanes held valid for four cycles, `out_ready_i`=1 → grants alternate 0,1,0,1 and `conflict_cnt_o`=4.
- Lane 1 `SUB` with 10 and 3 while `out_ready_i`=0 for three cycles → `out_result_o`=7 held stable and `req_ready_o`=0. On release, the next op is accepted in the same cycle as the drain.
- `flush_i` with a full register and both lanes valid → `out_valid_o`=0 next cycle, no grant, and the counter is unchanged.
- Preset `conflict_cnt_o` to `16'hFFFE` (by conflict stream) and run 3 further conflicts → the counter holds at `16'hFFFF`.
- Assert `reset` mid-stall with `out_valid_o`=1 → all outputs are 0 immediately, and the first post-reset conflict grants lane 0.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// ALU widths, opcodes and occupancy-state encodings shared by the
// execute-stage ALU sharing block.
package alu_share_arbiter_pkg;

  localparam int SIZE_DATA       = 32;
  localparam int SIZE_OPCODE_I   = 4;
  localparam int SIZE_IMMEDIATE  = 16;
  localparam int EXECUTION_FLAGS = 6;

  localparam logic [SIZE_OPCODE_I-1:0] OP_NOP  = 4'd0;
  localparam logic [SIZE_OPCODE_I-1:0] OP_ADD  = 4'd1;
  localparam logic [SIZE_OPCODE_I-1:0] OP_SUB  = 4'd2;
  localparam logic [SIZE_OPCODE_I-1:0] OP_AND  = 4'd3;
  localparam logic [SIZE_OPCODE_I-1:0] OP_OR   = 4'd4;
  localparam logic [SIZE_OPCODE_I-1:0] OP_XOR  = 4'd5;
  localparam logic [SIZE_OPCODE_I-1:0] OP_ADDI = 4'd6;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  typedef struct packed {
    logic [SIZE_OPCODE_I-1:0]  opcode;
    logic [SIZE_DATA-1:0]      data1;
    logic [SIZE_DATA-1:0]      data2;
    logic [SIZE_IMMEDIATE-1:0] immd;
  } alu_op_t;

  function automatic logic [SIZE_DATA-1:0] sext_immd(input logic [SIZE_IMMEDIATE-1:0] immd);
    return {{(SIZE_DATA-SIZE_IMMEDIATE){immd[SIZE_IMMEDIATE-1]}}, immd};
  endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational execute-stage ALU. Flags are
// {carry/borrow, op_valid, overflow, non_negative, zero, negative}.
module Simple_ALU
  import alu_share_arbiter_pkg::*;
(
  input  logic [SIZE_OPCODE_I-1:0]   opcode_i,
  input  logic [SIZE_DATA-1:0]       data1_i,
  input  logic [SIZE_DATA-1:0]       data2_i,
  input  logic [SIZE_IMMEDIATE-1:0]  immd_i,
  output logic [SIZE_DATA-1:0]       result_o,
  output logic [EXECUTION_FLAGS-1:0] flags_o
);

  logic [SIZE_DATA:0]   wide;
  logic [SIZE_DATA-1:0] res;
  logic [SIZE_DATA-1:0] opb;
  logic                 carry;
  logic                 ovf;
  logic                 is_op;

  always_comb begin
    wide  = '0;
    res   = '0;
    opb   = data2_i;
    carry = 1'b0;
    ovf   = 1'b0;
    is_op = 1'b1;
    case (opcode_i)
      OP_ADD, OP_ADDI: begin
        if (opcode_i == OP_ADDI) opb = sext_immd(immd_i);
        wide  = {1'b0, data1_i} + {1'b0, opb};
        res   = wide[SIZE_DATA-1:0];
        carry = wide[SIZE_DATA];
        ovf   = (data1_i[SIZE_DATA-1] == opb[SIZE_DATA-1]) &&
                (res[SIZE_DATA-1] != data1_i[SIZE_DATA-1]);
      end
      OP_SUB: begin
        wide  = {1'b0, data1_i} - {1'b0, data2_i};
        res   = wide[SIZE_DATA-1:0];
        carry = wide[SIZE_DATA];
        ovf   = (data1_i[SIZE_DATA-1] != data2_i[SIZE_DATA-1]) &&
                (res[SIZE_DATA-1] != data1_i[SIZE_DATA-1]);
      end
      OP_AND: res = data1_i & data2_i;
      OP_OR:  res = data1_i | data2_i;
      OP_XOR: res = data1_i ^ data2_i;
      default: is_op = 1'b0;
    endcase
    result_o = res;
    flags_o  = {carry, is_op, ovf, ~res[SIZE_DATA-1], is_op && (res == '0), res[SIZE_DATA-1]};
  end

endmodule

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the lane that did not win last is granted.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       en,
  output logic [1:0] grant
);

  logic last_grant_q, last_grant_d;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (&valid) grant = last_grant_q ? 2'b01 : 2'b10;
      else        grant = valid;
    end
    last_grant_d = last_grant_q;
    if (grant[1])      last_grant_d = 1'b1;
    else if (grant[0]) last_grant_d = 1'b0;
  end

  // Reset to lane 1 so that lane 0 wins the first conflict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_grant_q <= 1'b1;
    else       last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two issue lanes; the result lands in a one-entry
// output register that drains under valid/ready.
//   state    | meaning
//   ST_EMPTY | output register holds nothing
//   ST_FULL  | output register holds a result for writeback
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int TAG_W = 7,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 req_valid_i,
  output logic [1:0]                 req_ready_o,
  input  logic [SIZE_OPCODE_I-1:0]   req0_opcode_i,
  input  logic [SIZE_DATA-1:0]       req0_data1_i,
  input  logic [SIZE_DATA-1:0]       req0_data2_i,
  input  logic [SIZE_IMMEDIATE-1:0]  req0_immd_i,
  input  logic [TAG_W-1:0]           req0_tag_i,
  input  logic [SIZE_OPCODE_I-1:0]   req1_opcode_i,
  input  logic [SIZE_DATA-1:0]       req1_data1_i,
  input  logic [SIZE_DATA-1:0]       req1_data2_i,
  input  logic [SIZE_IMMEDIATE-1:0]  req1_immd_i,
  input  logic [TAG_W-1:0]           req1_tag_i,
  input  logic                       flush_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [SIZE_DATA-1:0]       out_result_o,
  output logic [EXECUTION_FLAGS-1:0] out_flags_o,
  output logic [TAG_W-1:0]           out_tag_o,
  output logic                       out_src_o,
  output logic [CNT_W-1:0]           conflict_cnt_o
);

  logic [0:0]                 state_q, state_d;
  logic [SIZE_DATA-1:0]       result_q, result_d;
  logic [EXECUTION_FLAGS-1:0] flags_q, flags_d;
  logic [TAG_W-1:0]           tag_q, tag_d;
  logic                       src_q, src_d;
  logic [CNT_W-1:0]           conflict_q, conflict_d;

  logic                       can_accept;
  logic                       arb_en;
  logic [1:0]                 grant;
  logic                       accept;
  logic                       sel;
  alu_op_t                    op_sel;
  logic [TAG_W-1:0]           tag_sel;
  logic [SIZE_DATA-1:0]       alu_result;
  logic [EXECUTION_FLAGS-1:0] alu_flags;

  assign can_accept = !flush_i && ((state_q == ST_EMPTY) || out_ready_i);
  // Gating with reset keeps req_ready_o low for the whole reset assertion.
  assign arb_en     = can_accept && !reset;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .valid (req_valid_i),
    .en    (arb_en),
    .grant (grant)
  );

  assign req_ready_o = grant;
  assign accept      = |grant;
  assign sel         = grant[1];

  always_comb begin
    if (sel) begin
      op_sel  = '{opcode: req1_opcode_i, data1: req1_data1_i, data2: req1_data2_i, immd: req1_immd_i};
      tag_sel = req1_tag_i;
    end else begin
      op_sel  = '{opcode: req0_opcode_i, data1: req0_data1_i, data2: req0_data2_i, immd: req0_immd_i};
      tag_sel = req0_tag_i;
    end
  end

  Simple_ALU u_alu (
    .opcode_i (op_sel.opcode),
    .data1_i  (op_sel.data1),
    .data2_i  (op_sel.data2),
    .immd_i   (op_sel.immd),
    .result_o (alu_result),
    .flags_o  (alu_flags)
  );

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    flags_d    = flags_q;
    tag_d      = tag_q;
    src_d      = src_q;
    conflict_d = conflict_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      default: begin
        if (flush_i)          state_d = ST_EMPTY;
        else if (accept)      state_d = ST_FULL;
        else if (out_ready_i) state_d = ST_EMPTY;
      end
    endcase
    if (accept) begin
      result_d = alu_result;
      flags_d  = alu_flags;
      tag_d    = tag_sel;
      src_d    = sel;
    end
    if ((&req_valid_i) && accept && (conflict_q != {CNT_W{1'b1}}))
      conflict_d = conflict_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      result_q   <= '0;
      flags_q    <= '0;
      tag_q      <= '0;
      src_q      <= 1'b0;
      conflict_q <= '0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      tag_q      <= tag_d;
      src_q      <= src_d;
      conflict_q <= conflict_d;
    end
  end

  assign out_valid_o    = (state_q == ST_FULL);
  assign out_result_o   = result_q;
  assign out_flags_o    = flags_q;
  assign out_tag_o      = tag_q;
  assign out_src_o      = src_q;
  assign conflict_cnt_o = conflict_q;

endmodule
